// File: rtl/vec_pkg.sv
// Shared types and constants for the vector load/store sequencer.
package vec_pkg;

  localparam int unsigned NUM_VREGS      = 32;
  localparam int unsigned VIDX_W         = $clog2(NUM_VREGS);
  localparam logic [3:0]  MEM_WSTRB_FULL = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VRD,
    S_LD_ISSUE,
    S_ST_ISSUE,
    S_VWR,
    S_DONE
  } vseq_state_e;

  // Latched command; the byte offset of the base is dropped at capture.
  typedef struct packed {
    logic              is_store;
    logic [29:0]       base_w;
    logic [VIDX_W-1:0] vidx;
  } vseq_cmd_t;

endpackage

// File: rtl/vector_lane_buffer.sv
// LANES x DATA_WIDTH staging buffer: indexed lane write, parallel load, sync clear.
module vector_lane_buffer #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr_i,
  input  logic                                 wr_en_i,
  input  logic [$clog2(LANES)-1:0]             wr_idx_i,
  input  logic [DATA_WIDTH-1:0]                wr_data_i,
  input  logic                                 load_en_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]     load_data_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0]     data_o
);

  logic [LANES-1:0][DATA_WIDTH-1:0] lanes_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      lanes_q <= '0;
    end else if (load_en_i) begin
      lanes_q <= load_data_i;
    end else if (wr_en_i) begin
      lanes_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign data_o = lanes_q;

endmodule

// File: rtl/vector_ldst_sequencer.sv
// Whole-vector load/store sequencer between the word-wide memory port and the vreg file.
module vector_ldst_sequencer
  import vec_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic                             cmd_is_store,
  input  logic [31:0]                      cmd_base_addr,
  input  logic [VIDX_W-1:0]                cmd_vreg_idx,
  output logic                             busy,
  output logic                             done,
  output logic                             vreg_rd_valid,
  output logic [VIDX_W-1:0]                vreg_rd_idx,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] vreg_rd_data,
  input  logic                             vreg_rd_ready,
  output logic                             vreg_wr_valid,
  output logic [VIDX_W-1:0]                vreg_wr_idx,
  output logic [LANES-1:0][DATA_WIDTH-1:0] vreg_wr_data,
  input  logic                             vreg_wr_ready,
  output logic                             mem_req_valid,
  output logic                             mem_req_is_write,
  output logic [31:0]                      mem_req_addr,
  output logic [DATA_WIDTH-1:0]            mem_req_wdata,
  output logic [3:0]                       mem_req_wstrb,
  input  logic                             mem_req_ready,
  input  logic [DATA_WIDTH-1:0]            mem_resp_rdata,
  input  logic                             mem_resp_valid,
  output logic                             mem_resp_ready
);

  localparam int unsigned CNT_W = $clog2(LANES) + 1;
  localparam int unsigned IDX_W = $clog2(LANES);

  vseq_state_e state_q;
  vseq_cmd_t   cmd_q;
  logic [CNT_W-1:0] iss_cnt_q;
  logic [CNT_W-1:0] rsp_cnt_q;

  logic [IDX_W-1:0] iss_lane;
  logic buf_clr;
  logic buf_load_en;
  logic buf_wr_en;
  logic [LANES-1:0][DATA_WIDTH-1:0] buf_data;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^cmd_base_addr[1:0];
  assign iss_lane         = iss_cnt_q[IDX_W-1:0];

  // All handshake outputs decode from registered state/counters only.
  assign cmd_ready        = (state_q == S_IDLE);
  assign busy             = (state_q != S_IDLE);
  assign done             = (state_q == S_DONE);
  assign vreg_rd_valid    = (state_q == S_VRD);
  assign vreg_rd_idx      = cmd_q.vidx;
  assign vreg_wr_valid    = (state_q == S_VWR);
  assign vreg_wr_idx      = cmd_q.vidx;
  assign vreg_wr_data     = buf_data;
  assign mem_req_is_write = (state_q == S_ST_ISSUE);
  assign mem_req_valid    = (state_q == S_ST_ISSUE) ||
                            ((state_q == S_LD_ISSUE) && (iss_cnt_q < CNT_W'(LANES)));
  assign mem_req_addr     = {cmd_q.base_w, 2'b00} + (32'(iss_cnt_q) << 2);
  assign mem_req_wdata    = mem_req_is_write ? buf_data[iss_lane] : '0;
  assign mem_req_wstrb    = mem_req_is_write ? MEM_WSTRB_FULL : 4'h0;
  assign mem_resp_ready   = 1'b1;

  always_comb begin
    buf_clr     = (state_q == S_IDLE) && cmd_valid;
    buf_load_en = (state_q == S_VRD) && vreg_rd_ready;
    buf_wr_en   = (state_q == S_LD_ISSUE) && mem_resp_valid;
  end

  vector_lane_buffer #(
    .LANES      (LANES),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (buf_clr),
    .wr_en_i     (buf_wr_en),
    .wr_idx_i    (rsp_cnt_q[IDX_W-1:0]),
    .wr_data_i   (mem_resp_rdata),
    .load_en_i   (buf_load_en),
    .load_data_i (vreg_rd_data),
    .data_o      (buf_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      iss_cnt_q <= '0;
      rsp_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            cmd_q.is_store <= cmd_is_store;
            cmd_q.base_w   <= cmd_base_addr[31:2];
            cmd_q.vidx     <= cmd_vreg_idx;
            iss_cnt_q      <= '0;
            rsp_cnt_q      <= '0;
            state_q        <= cmd_is_store ? S_VRD : S_LD_ISSUE;
          end
        end
        S_VRD: begin
          if (vreg_rd_ready) state_q <= S_ST_ISSUE;
        end
        S_ST_ISSUE: begin
          if (mem_req_ready) begin
            iss_cnt_q <= iss_cnt_q + CNT_W'(1);
            if (iss_cnt_q == CNT_W'(LANES - 1)) state_q <= S_DONE;
          end
        end
        S_LD_ISSUE: begin
          // Issue and response counters advance independently in the same cycle.
          if (mem_req_valid && mem_req_ready) iss_cnt_q <= iss_cnt_q + CNT_W'(1);
          if (mem_resp_valid) begin
            rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
            if (rsp_cnt_q == CNT_W'(LANES - 1)) state_q <= S_VWR;
          end
        end
        S_VWR: begin
          if (vreg_wr_ready) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
